pc_sequencer: RTL and testbench

Program-counter sequencer that owns the instruction address register and drives the instruction memory fetch address every cycle. It decodes the 3-bit branch opcode and ALU flags from the current instruction and selects among the sequential, branch and return targets. It extends the single link register to a hardware return-address stack (RAS) so that subroutine calls can nest. Overflow and underflow of the RAS are trapped. It sits between the control decoder/ALU flag outputs and the instruction memory address port.

---
 rtl/seq_pkg.sv | 17 +
 rtl/ras_stack.sv | 40 ++++
 rtl/pc_sequencer.sv | 100 ++++++++++
 tb/tb_pc_sequencer.sv | 123 ++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared encodings for the program-counter sequencer: branch opcodes and FSM states.
package seq_pkg;

   localparam logic [2:0] BROP_SEQ  = 3'b000;
   localparam logic [2:0] BROP_BRZ  = 3'b001;
   localparam logic [2:0] BROP_BRN  = 3'b010;
   localparam logic [2:0] BROP_CALL = 3'b011;
   localparam logic [2:0] BROP_BR   = 3'b100;
   localparam logic [2:0] BROP_RET  = 3'b101;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

endpackage

// File: rtl/ras_stack.sv
// Hardware return-address stack: LIFO of RAS_DEPTH entries, top readable the cycle after a push.
module ras_stack #(
   parameter int ADDR_W    = 8,
   parameter int RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] din,
   output logic [ADDR_W-1:0] top,
   output logic              empty,
   output logic              full
);

   localparam int IDX_W = $clog2(RAS_DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [ADDR_W-1:0] mem [RAS_DEPTH];
   logic [PTR_W-1:0]  count_reg;
   logic [PTR_W-1:0]  top_ptr;

   // Contents are don't-care after reset; only the occupancy count is cleared.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count_reg <= '0;
      end else if (push && !full) begin
         mem[count_reg[IDX_W-1:0]] <= din;
         count_reg <= count_reg + 1'b1;
      end else if (pop && !empty) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign top_ptr = count_reg - 1'b1;
   assign top     = mem[top_ptr[IDX_W-1:0]];
   assign empty   = (count_reg == '0);
   assign full    = (count_reg == PTR_W'(RAS_DEPTH));

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT/RUN/FAULT FSM, next-PC selection and RAS trap logic.
module pc_sequencer
   import seq_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int PC_STEP   = 2,
   parameter int RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic [2:0]        brop,
   input  logic              zero,
   input  logic              neg,
   input  logic [ADDR_W-1:0] br_addr,
   output logic [ADDR_W-1:0] pc,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              fault
);

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] pc_reg, pc_next;
   logic [ADDR_W-1:0] seq_addr;
   logic [ADDR_W-1:0] ras_top;
   logic              push, pop;

   assign seq_addr = pc_reg + ADDR_W'(PC_STEP);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= ST_BOOT;
         pc_reg    <= '0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      push       = 1'b0;
      pop        = 1'b0;
      case (state_reg)
         ST_BOOT: begin
            state_next = ST_RUN;
            pc_next    = '0;
         end
         ST_RUN: begin
            if (!stall) begin
               case (brop)
                  BROP_BRZ: pc_next = zero ? br_addr : seq_addr;
                  BROP_BRN: pc_next = neg ? br_addr : seq_addr;
                  BROP_BR:  pc_next = br_addr;
                  // A trapped CALL/RET leaves pc and the stack untouched.
                  BROP_CALL: begin
                     if (ras_full) begin
                        state_next = ST_FAULT;
                     end else begin
                        push    = 1'b1;
                        pc_next = br_addr;
                     end
                  end
                  BROP_RET: begin
                     if (ras_empty) begin
                        state_next = ST_FAULT;
                     end else begin
                        pop     = 1'b1;
                        pc_next = ras_top;
                     end
                  end
                  default: pc_next = seq_addr;
               endcase
            end
         end
         default: begin
            state_next = ST_FAULT;
         end
      endcase
   end

   ras_stack #(
      .ADDR_W   (ADDR_W),
      .RAS_DEPTH(RAS_DEPTH)
   ) u_ras (
      .clk  (clk),
      .rst  (rst),
      .push (push),
      .pop  (pop),
      .din  (seq_addr),
      .top  (ras_top),
      .empty(ras_empty),
      .full (ras_full)
   );

   assign pc    = pc_reg;
   assign fault = (state_reg == ST_FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed expected pc/flag values.
module tb_pc_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       stall = 1'b0;
   logic [2:0] brop = 3'b000;
   logic       zero = 1'b0;
   logic       neg = 1'b0;
   logic [7:0] br_addr = 8'h00;
   logic [7:0] pc;
   logic       ras_empty, ras_full, fault;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pc_sequencer #(.ADDR_W(8), .PC_STEP(2), .RAS_DEPTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .stall    (stall),
      .brop     (brop),
      .zero     (zero),
      .neg      (neg),
      .br_addr  (br_addr),
      .pc       (pc),
      .ras_empty(ras_empty),
      .ras_full (ras_full),
      .fault    (fault)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, clock it, then sample 1 ns after the edge.
   task automatic cyc(input logic [2:0] op, input logic [7:0] addr,
                      input logic z, input logic n, input logic s);
      brop    = op;
      br_addr = addr;
      zero    = z;
      neg     = n;
      stall   = s;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input logic [7:0] exp_pc,
                            input logic exp_empty, input logic exp_full, input logic exp_fault);
      chk({tag, ".pc"}, pc, exp_pc);
      chk({tag, ".empty"}, {7'd0, ras_empty}, {7'd0, exp_empty});
      chk({tag, ".full"}, {7'd0, ras_full}, {7'd0, exp_full});
      chk({tag, ".fault"}, {7'd0, fault}, {7'd0, exp_fault});
      $display("%-14s pc=%h empty=%b full=%b fault=%b", tag, pc, ras_empty, ras_full, fault);
   endtask

   initial begin
      // Reset held three cycles with a branch on the inputs.
      rst = 1'b0;
      for (int i = 0; i < 3; i++) cyc(3'b100, 8'h40, 1'b0, 1'b0, 1'b0);
      chk_state("reset", 8'h00, 1'b1, 1'b0, 1'b0);

      rst = 1'b1;
      cyc(3'b000, 8'h00, 1'b0, 1'b0, 1'b0); chk_state("boot", 8'h00, 1'b1, 1'b0, 1'b0);
      cyc(3'b000, 8'h00, 1'b0, 1'b0, 1'b0); chk_state("seq1", 8'h02, 1'b1, 1'b0, 1'b0);
      cyc(3'b000, 8'h00, 1'b0, 1'b0, 1'b0); chk_state("seq2", 8'h04, 1'b1, 1'b0, 1'b0);

      // Nested calls from 0x04.
      cyc(3'b011, 8'h40, 1'b0, 1'b0, 1'b0); chk_state("call1", 8'h40, 1'b0, 1'b0, 1'b0);
      cyc(3'b011, 8'h60, 1'b0, 1'b0, 1'b0); chk_state("call2", 8'h60, 1'b0, 1'b0, 1'b0);
      cyc(3'b101, 8'h00, 1'b0, 1'b0, 1'b0); chk_state("ret1", 8'h42, 1'b0, 1'b0, 1'b0);
      cyc(3'b101, 8'h00, 1'b0, 1'b0, 1'b0); chk_state("ret2", 8'h06, 1'b1, 1'b0, 1'b0);

      // Conditional branches, flags ignored for other opcodes.
      cyc(3'b100, 8'h10, 1'b0, 1'b0, 1'b0); chk_state("br", 8'h10, 1'b1, 1'b0, 1'b0);
      cyc(3'b001, 8'h80, 1'b0, 1'b1, 1'b0); chk_state("brz_nt", 8'h12, 1'b1, 1'b0, 1'b0);
      cyc(3'b001, 8'h80, 1'b1, 1'b0, 1'b0); chk_state("brz_t", 8'h80, 1'b1, 1'b0, 1'b0);
      cyc(3'b010, 8'h20, 1'b0, 1'b1, 1'b0); chk_state("brn_t", 8'h20, 1'b1, 1'b0, 1'b0);
      cyc(3'b010, 8'h90, 1'b1, 1'b0, 1'b0); chk_state("brn_nt", 8'h22, 1'b1, 1'b0, 1'b0);
      cyc(3'b110, 8'h90, 1'b1, 1'b1, 1'b0); chk_state("op110", 8'h24, 1'b1, 1'b0, 1'b0);
      cyc(3'b111, 8'h90, 1'b1, 1'b1, 1'b0); chk_state("op111", 8'h26, 1'b1, 1'b0, 1'b0);

      // Stalled CALL, then the push on the first unstalled edge; back-to-back RET.
      cyc(3'b011, 8'h50, 1'b0, 1'b0, 1'b1); chk_state("stall1", 8'h26, 1'b1, 1'b0, 1'b0);
      cyc(3'b011, 8'h50, 1'b0, 1'b0, 1'b1); chk_state("stall2", 8'h26, 1'b1, 1'b0, 1'b0);
      cyc(3'b011, 8'h50, 1'b0, 1'b0, 1'b0); chk_state("call_go", 8'h50, 1'b0, 1'b0, 1'b0);
      cyc(3'b101, 8'h00, 1'b0, 1'b0, 1'b0); chk_state("ret_b2b", 8'h28, 1'b1, 1'b0, 1'b0);

      // Sequential wrap 0xFE -> 0x00.
      cyc(3'b100, 8'hFE, 1'b0, 1'b0, 1'b0); chk_state("to_fe", 8'hFE, 1'b1, 1'b0, 1'b0);
      cyc(3'b000, 8'h00, 1'b0, 1'b0, 1'b0); chk_state("wrap", 8'h00, 1'b1, 1'b0, 1'b0);

      // Overflow: four CALLs fill the RAS, the fifth traps.
      cyc(3'b011, 8'h10, 1'b0, 1'b0, 1'b0); chk_state("ovf_c1", 8'h10, 1'b0, 1'b0, 1'b0);
      cyc(3'b011, 8'h20, 1'b0, 1'b0, 1'b0); chk_state("ovf_c2", 8'h20, 1'b0, 1'b0, 1'b0);
      cyc(3'b011, 8'h30, 1'b0, 1'b0, 1'b0); chk_state("ovf_c3", 8'h30, 1'b0, 1'b0, 1'b0);
      cyc(3'b011, 8'h40, 1'b0, 1'b0, 1'b0); chk_state("ovf_c4", 8'h40, 1'b0, 1'b1, 1'b0);
      cyc(3'b011, 8'h50, 1'b0, 1'b0, 1'b0); chk_state("ovf_c5", 8'h40, 1'b0, 1'b1, 1'b1);
      cyc(3'b100, 8'h70, 1'b0, 1'b0, 1'b0); chk_state("flt_br", 8'h40, 1'b0, 1'b1, 1'b1);
      cyc(3'b101, 8'h00, 1'b0, 1'b0, 1'b0); chk_state("flt_ret", 8'h40, 1'b0, 1'b1, 1'b1);

      // Reset while in FAULT, applied during a stall.
      rst = 1'b0;
      cyc(3'b100, 8'h70, 1'b0, 1'b0, 1'b1); chk_state("flt_rst", 8'h00, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      cyc(3'b000, 8'h00, 1'b0, 1'b0, 1'b0); chk_state("boot2", 8'h00, 1'b1, 1'b0, 1'b0);
      cyc(3'b000, 8'h00, 1'b0, 1'b0, 1'b0); chk_state("seq3", 8'h02, 1'b1, 1'b0, 1'b0);

      // Underflow: RET on an empty stack traps with pc unchanged.
      cyc(3'b101, 8'h00, 1'b0, 1'b0, 1'b0); chk_state("unf", 8'h02, 1'b1, 1'b0, 1'b1);
      cyc(3'b000, 8'h00, 1'b0, 1'b0, 1'b0); chk_state("unf_hold", 8'h02, 1'b1, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
